// File: rtl/booth_multiplier_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier.
package mult_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int ITER_DEF  = WIDTH_DEF;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef enum logic [1:0] {NOP, ADD, SUB}   booth_op_e;

    function automatic booth_op_e booth_op(input logic q0, input logic qm1);
        case ({q0, qm1})
            2'b01:   return ADD;
            2'b10:   return SUB;
            default: return NOP;
        endcase
    endfunction
endpackage

// File: rtl/booth_multiplier_if.sv
// Start/operand/result bundle between the execute stage and the multiplier.
interface booth_multiplier_if import mult_pkg::*; #(parameter int WIDTH = WIDTH_DEF) ();
    logic             ctrl_MULT;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (output ctrl_MULT, data_operandA, data_operandB,
                    input  data_result, data_exception, data_resultRDY, busy);
    modport slave  (input  ctrl_MULT, data_operandA, data_operandB,
                    output data_result, data_exception, data_resultRDY, busy);
endinterface

// File: rtl/booth_multiplier_booth_step.sv
// One Booth add/sub/nop step on the WIDTH+1-bit accumulator, plus the 32-bit CLA it uses.
module cla_adder32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);
    logic [31:0] g, p;
    logic [32:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // 4-bit lookahead groups, group carries chained.
    always_comb begin
        c    = '0;
        c[0] = cin_i;
        for (int j = 0; j < 8; j++) begin
            c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & c[4*j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
            c[4*j+4] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j])
                     | (&p[4*j +: 4] & c[4*j]);
        end
    end

    assign sum_o  = p ^ c[31:0];
    assign cout_o = c[32];
endmodule

module booth_step import mult_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
    input  logic [WIDTH:0] acc_i,
    input  logic [WIDTH:0] m_i,
    input  logic           q0_i,
    input  logic           qm1_i,
    output logic [WIDTH:0] acc_o
);
    booth_op_e        op;
    logic             sub;
    logic [WIDTH:0]   m_sel;
    logic [WIDTH-1:0] sum;
    logic             cout;

    assign op    = booth_op(q0_i, qm1_i);
    assign sub   = (op == SUB);
    assign m_sel = sub ? ~m_i : m_i;

    cla_adder32 u_cla (
        .a_i    (acc_i[WIDTH-1:0]),
        .b_i    (m_sel[WIDTH-1:0]),
        .cin_i  (sub),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // Top accumulator bit finishes the WIDTH+1-bit add from the adder carry-out.
    assign acc_o = (op == NOP) ? acc_i : {acc_i[WIDTH] ^ m_sel[WIDTH] ^ cout, sum};
endmodule

// File: rtl/booth_multiplier.sv
// Iterative radix-2 Booth signed multiplier, 33-cycle latency, truncated product + overflow.
// MULT_EARLY_EXIT_EN: zero operand at start skips RUN and completes in one cycle.
module booth_multiplier import mult_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ITER  = WIDTH
) (
    input logic               clock,
    input logic               reset,
    booth_multiplier_if.slave bus
);
    localparam int PW = 2*WIDTH + 2;

    state_e           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [PW-1:0]    p_q, p_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;

    logic [WIDTH:0]   acc_next;
    logic [PW-1:0]    p_shift;
    logic [WIDTH:0]   hi_bits;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_i (p_q[PW-1:WIDTH+1]),
        .m_i   (m_q),
        .q0_i  (p_q[1]),
        .qm1_i (p_q[0]),
        .acc_o (acc_next)
    );

    assign p_shift = {acc_next[WIDTH], acc_next, p_q[WIDTH:1]};
    // Product bits [2W-1:W-1] must all match for the result to fit signed WIDTH.
    assign hi_bits = p_shift[2*WIDTH:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        p_d     = p_q;
        res_d   = res_q;
        exc_d   = exc_q;
        case (state_q)
            IDLE: if (bus.ctrl_MULT) begin
                m_d     = {bus.data_operandA[WIDTH-1], bus.data_operandA};
                p_d     = {{(WIDTH+1){1'b0}}, bus.data_operandB, 1'b0};
                cnt_d   = '0;
                state_d = RUN;
`ifdef MULT_EARLY_EXIT_EN
                if (bus.data_operandA == '0 || bus.data_operandB == '0) begin
                    res_d   = '0;
                    exc_d   = 1'b0;
                    state_d = DONE;
                end
`endif
            end
            RUN: begin
                p_d   = p_shift;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(ITER-1)) begin
                    res_d   = p_shift[WIDTH:1];
                    exc_d   = !((&hi_bits) || !(|hi_bits));
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            p_q     <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            p_q     <= p_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    assign bus.data_result    = res_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state_q == DONE);
    assign bus.busy           = (state_q == RUN);
endmodule

// File: tb/tb_booth_multiplier.sv
// Directed-vector bench for booth_multiplier: latency, busy window, result/overflow, restart and reset corners.
module tb_booth_multiplier;
    import mult_pkg::*;

`ifdef MULT_EARLY_EXIT_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    booth_multiplier_if bus ();

    booth_multiplier dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        int          lat;
    } vec_t;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Start on the next edge, then watch 40 cycles; cycle n is sampled after the n-th edge past start.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input int restart_at,
                           input int exp_lat, output int lat, output int nrdy, output int busy_bad);
        @(negedge clock);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = 1'b1;
        lat = 0; nrdy = 0; busy_bad = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (bus.data_resultRDY) begin
                nrdy++;
                if (lat == 0) lat = n;
            end
            if (bus.busy !== (n < exp_lat)) busy_bad++;
            bus.ctrl_MULT = (n == restart_at);
            if (n == restart_at) begin
                bus.data_operandA = 32'd9;
                bus.data_operandB = 32'd9;
            end else begin
                bus.data_operandA = $urandom;
                bus.data_operandB = $urandom;
            end
        end
    endtask

    vec_t tbl[9];
    int   lat, nrdy, busy_bad;

    initial begin
        tbl[0] = '{32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33};
        tbl[1] = '{32'h7FFF_FFFF, 32'd2,        32'hFFFF_FFFE, 1'b1, 33};
        tbl[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33};
        tbl[3] = '{32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0, 33};
        tbl[4] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 33};
        // -46341 * 46341 = -2147488281, below INT_MIN, so it wraps and overflows.
        tbl[5] = '{32'hFFFF_4AFB, 32'h0000_B505, 32'h7FFF_EDE7, 1'b1, 33};
        tbl[6] = '{32'hFFFF_4AFC, 32'h0000_B504, 32'h8001_57F0, 1'b0, 33};
        tbl[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33};
        tbl[8] = '{32'd0,        32'd1234,     32'h0000_0000, 1'b0, ZLAT};

        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) @(negedge clock);
        chk("reset_outputs", {bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy}, '0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            do_mult(tbl[i].a, tbl[i].b, 0, tbl[i].lat, lat, nrdy, busy_bad);
            chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_rdy_count", i), nrdy, 1);
            chk($sformatf("v%0d_busy_window", i), busy_bad, 0);
            chk($sformatf("v%0d_result", i), bus.data_result, tbl[i].res);
            chk($sformatf("v%0d_exception", i), bus.data_exception, tbl[i].exc);
        end

        // Restart attempt mid-run must be ignored.
        do_mult(32'd5, 32'd6, 10, 33, lat, nrdy, busy_bad);
        chk("restart_latency", lat, 33);
        chk("restart_rdy_count", nrdy, 1);
        chk("restart_busy_window", busy_bad, 0);
        chk("restart_result", bus.data_result, 32'd30);

        // Reset in cycle 15 of a run clears everything on the next cycle.
        @(negedge clock);
        bus.data_operandA = 32'd5;
        bus.data_operandB = 32'd7;
        bus.ctrl_MULT     = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clock);
            bus.ctrl_MULT = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrun_reset_outputs", {bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy}, '0);

        do_mult(32'd3, 32'd4, 0, 33, lat, nrdy, busy_bad);
        chk("post_reset_latency", lat, 33);
        chk("post_reset_result", bus.data_result, 32'd12);
        chk("post_reset_exception", bus.data_exception, 1'b0);

        // Start coincident with reset: reset wins, nothing launches.
        @(negedge clock);
        reset             = 1'b1;
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd3;
        bus.data_operandB = 32'd4;
        @(negedge clock);
        reset         = 1'b0;
        bus.ctrl_MULT = 1'b0;
        nrdy = 0; busy_bad = 0;
        for (int n = 1; n <= 36; n++) begin
            if (bus.data_resultRDY) nrdy++;
            if (bus.busy) busy_bad++;
            @(negedge clock);
        end
        chk("reset_vs_start_rdy", nrdy, 0);
        chk("reset_vs_start_busy", busy_bad, 0);
        chk("reset_vs_start_result", bus.data_result, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
